// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the AXI memory bus arbiter.
// Optional round-robin read arbitration is enabled by MEM_ARB_RR_EN.
package mem_bus_arbiter_pkg;

    localparam int         LINE_WORDS_DEF = 4;
    localparam logic [3:0] AXI_ID_IC      = 4'd0;
    localparam logic [3:0] AXI_ID_DC      = 4'd1;
    localparam logic [1:0] BURST_INCR     = 2'b01;
    localparam logic [2:0] SIZE_WORD      = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B
    } arb_state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } arb_owner_t;

    function automatic logic [7:0] burst_len(input logic cached, input int words);
        return cached ? 8'(words - 1) : 8'd0;
    endfunction

endpackage

// File: rtl/mem_arb_wbuf.sv
// Write buffer: holds the granted line and steps through it one W beat at a time.
// Produces wdata for the current beat and flags the final beat.
module mem_arb_wbuf
    import mem_bus_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [32*LINE_WORDS-1:0] line_in,
    input  logic                     clr,
    input  logic                     adv,
    input  logic [7:0]               last_idx,
    output logic [31:0]              wdata,
    output logic                     wlast
);

    localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    logic [LINE_WORDS-1:0][31:0] line_q, line_d;
    logic [CW-1:0]               cnt_q, cnt_d;

    always_comb begin
        line_d = line_q;
        cnt_d  = cnt_q;
        if (load) begin
            line_d = line_in;
        end
        if (clr) begin
            cnt_d = '0;
        end else if (adv) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
        end
    end

    assign wdata = line_q[cnt_q];
    assign wlast = (8'(cnt_q) == last_idx);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding AXI master shared by icache reads, dcache reads and dcache writes.
// Define MEM_ARB_RR_EN for round-robin between the two read requesters.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ic_rd_req,
    input  logic [31:0]              ic_rd_addr,
    input  logic                     ic_rd_cached,
    output logic                     ic_rd_gnt,
    output logic                     ic_rd_valid,
    output logic                     ic_rd_last,
    input  logic                     dc_rd_req,
    input  logic [31:0]              dc_rd_addr,
    input  logic                     dc_rd_cached,
    input  logic [1:0]               dc_rd_byte_type,
    output logic                     dc_rd_gnt,
    output logic                     dc_rd_valid,
    output logic                     dc_rd_last,
    output logic [31:0]              rd_data,
    input  logic                     dc_wr_req,
    input  logic [31:0]              dc_wr_addr,
    input  logic                     dc_wr_cached,
    input  logic [32*LINE_WORDS-1:0] dc_wr_line,
    input  logic [3:0]               dc_wr_strb,
    output logic                     dc_wr_gnt,
    output logic                     dc_wr_done,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [3:0]               arid,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [31:0]              rdata,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [31:0]              awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic [3:0]               awid,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic                     bvalid,
    output logic                     bready
);

    arb_state_t  state_q, state_d;
    arb_owner_t  owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic        cached_q, cached_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  strb_q, strb_d;
    logic        pick_dc;
    logic        wb_load, wb_clr, wb_adv, wb_last;
    logic [7:0]  len;
    logic        rd_beat;

`ifdef MEM_ARB_RR_EN
    arb_owner_t  rr_q, rr_d;
    assign pick_dc = dc_rd_req & (!ic_rd_req | (rr_q == OWN_DC));
`else
    assign pick_dc = dc_rd_req;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        cached_d  = cached_q;
        size_d    = size_q;
        strb_d    = strb_q;
        ic_rd_gnt = 1'b0;
        dc_rd_gnt = 1'b0;
        dc_wr_gnt = 1'b0;
        wb_load   = 1'b0;
        wb_clr    = 1'b0;
`ifdef MEM_ARB_RR_EN
        rr_d      = rr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // Victim writeback always goes ahead of the refill that evicted it
                if (dc_wr_req) begin
                    dc_wr_gnt = 1'b1;
                    wb_load   = 1'b1;
                    addr_d    = dc_wr_addr;
                    cached_d  = dc_wr_cached;
                    strb_d    = dc_wr_strb;
                    size_d    = SIZE_WORD;
                    owner_d   = OWN_DC;
                    state_d   = ST_AW;
                end else if (pick_dc) begin
                    dc_rd_gnt = 1'b1;
                    addr_d    = dc_rd_addr;
                    cached_d  = dc_rd_cached;
                    size_d    = dc_rd_cached ? SIZE_WORD : {1'b0, dc_rd_byte_type};
                    owner_d   = OWN_DC;
                    state_d   = ST_AR;
`ifdef MEM_ARB_RR_EN
                    rr_d      = OWN_IC;
`endif
                end else if (ic_rd_req) begin
                    ic_rd_gnt = 1'b1;
                    addr_d    = ic_rd_addr;
                    cached_d  = ic_rd_cached;
                    size_d    = SIZE_WORD;
                    owner_d   = OWN_IC;
                    state_d   = ST_AR;
`ifdef MEM_ARB_RR_EN
                    rr_d      = OWN_DC;
`endif
                end
            end
            ST_AR: if (arready) state_d = ST_R;
            ST_R:  if (rvalid && rlast) state_d = ST_IDLE;
            ST_AW: begin
                if (awready) begin
                    wb_clr  = 1'b1;
                    state_d = ST_W;
                end
            end
            ST_W:  if (wready && wb_last) state_d = ST_B;
            ST_B:  if (bvalid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_IC;
            addr_q   <= '0;
            cached_q <= 1'b0;
            size_q   <= '0;
            strb_q   <= '0;
`ifdef MEM_ARB_RR_EN
            rr_q     <= OWN_IC;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            cached_q <= cached_d;
            size_q   <= size_d;
            strb_q   <= strb_d;
`ifdef MEM_ARB_RR_EN
            rr_q     <= rr_d;
`endif
        end
    end

    assign wb_adv = (state_q == ST_W) & wready;

    mem_arb_wbuf #(
        .LINE_WORDS(LINE_WORDS)
    ) u_wbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (wb_load),
        .line_in (dc_wr_line),
        .clr     (wb_clr),
        .adv     (wb_adv),
        .last_idx(len),
        .wdata   (wdata),
        .wlast   (wb_last)
    );

    assign len     = burst_len(cached_q, LINE_WORDS);

    assign arvalid = (state_q == ST_AR);
    assign araddr  = addr_q;
    assign arlen   = len;
    assign arsize  = size_q;
    assign arburst = BURST_INCR;
    assign arid    = (owner_q == OWN_DC) ? AXI_ID_DC : AXI_ID_IC;

    assign rready      = (state_q == ST_R);
    assign rd_beat     = rready & rvalid;
    assign rd_data     = rdata;
    assign ic_rd_valid = rd_beat & (owner_q == OWN_IC);
    assign dc_rd_valid = rd_beat & (owner_q == OWN_DC);
    assign ic_rd_last  = ic_rd_valid & rlast;
    assign dc_rd_last  = dc_rd_valid & rlast;

    assign awvalid = (state_q == ST_AW);
    assign awaddr  = addr_q;
    assign awlen   = len;
    assign awsize  = size_q;
    assign awburst = BURST_INCR;
    assign awid    = AXI_ID_DC;

    assign wvalid  = (state_q == ST_W);
    assign wstrb   = cached_q ? 4'hf : strb_q;
    assign wlast   = wvalid & wb_last;

    assign bready     = (state_q == ST_B);
    assign dc_wr_done = bready & bvalid;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: random requests, random-latency AXI slave.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int LW = 4;

    logic          clk, rst_n;
    logic          ic_rd_req, ic_rd_cached, ic_rd_gnt, ic_rd_valid, ic_rd_last;
    logic [31:0]   ic_rd_addr;
    logic          dc_rd_req, dc_rd_cached, dc_rd_gnt, dc_rd_valid, dc_rd_last;
    logic [31:0]   dc_rd_addr, rd_data;
    logic [1:0]    dc_rd_byte_type;
    logic          dc_wr_req, dc_wr_cached, dc_wr_gnt, dc_wr_done;
    logic [31:0]   dc_wr_addr;
    logic [32*LW-1:0] dc_wr_line;
    logic [3:0]    dc_wr_strb;
    logic [31:0]   araddr, awaddr, rdata, wdata;
    logic [7:0]    arlen, awlen;
    logic [2:0]    arsize, awsize;
    logic [1:0]    arburst, awburst;
    logic [3:0]    arid, awid, wstrb;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    mem_bus_arbiter #(.LINE_WORDS(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_cached(ic_rd_cached),
        .ic_rd_gnt(ic_rd_gnt), .ic_rd_valid(ic_rd_valid), .ic_rd_last(ic_rd_last),
        .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_cached(dc_rd_cached),
        .dc_rd_byte_type(dc_rd_byte_type), .dc_rd_gnt(dc_rd_gnt),
        .dc_rd_valid(dc_rd_valid), .dc_rd_last(dc_rd_last), .rd_data(rd_data),
        .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_cached(dc_wr_cached),
        .dc_wr_line(dc_wr_line), .dc_wr_strb(dc_wr_strb),
        .dc_wr_gnt(dc_wr_gnt), .dc_wr_done(dc_wr_done),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arid(arid), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awid(awid), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit               wr;
        bit               dc;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [3:0]       strb;
        logic [LW-1:0][31:0] line;
    } txn_t;

    txn_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    int   mon_beat = 0;
    bit   mon_act  = 1'b0;
    bit   rr_dc    = 1'b0;
    int   r_left   = 0;
    bit   b_pend   = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // AXI slave with random ready/valid gaps
    initial begin
        {arready, awready, wready, rvalid, rlast, bvalid} = '0;
        rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                r_left = 0;
                b_pend = 1'b0;
                {arready, awready, wready, rvalid, rlast, bvalid} = '0;
                continue;
            end
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            rvalid  = (r_left > 0) && ($urandom_range(0, 2) != 0);
            rlast   = rvalid && (r_left == 1);
            rdata   = $urandom;
            bvalid  = b_pend && ($urandom_range(0, 1) != 0);
            #1;
            if (arvalid && arready) r_left = int'(arlen) + 1;
            if (rvalid && rready) r_left--;
            if (wvalid && wready && wlast) b_pend = 1'b1;
            if (bvalid && bready) b_pend = 1'b0;
        end
    end

    // Monitor: compares DUT activity against the head of the expected queue
    initial begin
        txn_t       h;
        bit         have;
        bit         prev_g;
        logic [2:0] g;
        prev_g = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                mon_act  = 1'b0;
                mon_beat = 0;
                prev_g   = 1'b0;
                continue;
            end
            have = (exp_q.size() > 0);
            if (have) h = exp_q[0];
            if (prev_g && have)
                chk("valid_after_gnt", 128'({arvalid, awvalid}), 128'(h.wr ? 2'b01 : 2'b10));
            prev_g = 1'b0;
            g = {dc_wr_gnt, dc_rd_gnt, ic_rd_gnt};
            if (g != 3'b000) begin
                if (!have || mon_act) bad("spurious_gnt");
                else begin
                    chk("gnt", 128'(g), 128'(h.wr ? 3'b100 : (h.dc ? 3'b010 : 3'b001)));
                    mon_act  = 1'b1;
                    mon_beat = 0;
                    prev_g   = 1'b1;
                end
            end
            if (arvalid && have && h.wr) bad("ar_during_write");
            if (arvalid && arready && have && !h.wr) begin
                chk("araddr", 128'(araddr), 128'(h.addr));
                chk("arlen", 128'(arlen), 128'(h.len));
                chk("arsize", 128'(arsize), 128'(h.size));
                chk("arid", 128'(arid), 128'(h.dc ? 4'd1 : 4'd0));
                chk("arburst", 128'(arburst), 128'(2'b01));
            end
            if (awvalid && awready && have) begin
                chk("aw_is_write", 128'(h.wr), 128'(1'b1));
                chk("awaddr", 128'(awaddr), 128'(h.addr));
                chk("awlen", 128'(awlen), 128'(h.len));
                chk("awid", 128'(awid), 128'(4'd1));
                chk("awburst", 128'(awburst), 128'(2'b01));
            end
            if (wvalid && wready && have) begin
                chk("wdata", 128'(wdata), 128'(h.line[mon_beat % LW]));
                chk("wstrb", 128'(wstrb), 128'(h.strb));
                chk("wlast", 128'(wlast), 128'(mon_beat == int'(h.len)));
                mon_beat++;
            end
            if (rvalid && rready && have) begin
                chk("rd_valid", 128'({dc_rd_valid, ic_rd_valid}), 128'(h.dc ? 2'b10 : 2'b01));
                chk("rd_data", 128'(rd_data), 128'(rdata));
                chk("rd_last", 128'({dc_rd_last, ic_rd_last}),
                    128'((mon_beat == int'(h.len)) ? (h.dc ? 2'b10 : 2'b01) : 2'b00));
                mon_beat++;
                if (rlast) begin
                    void'(exp_q.pop_front());
                    mon_act = 1'b0;
                end
            end else begin
                chk("rd_valid_idle", 128'({dc_rd_valid, ic_rd_valid}), 128'(2'b00));
            end
            if (bvalid && bready && have) begin
                chk("wr_done", 128'(dc_wr_done), 128'(1'b1));
                void'(exp_q.pop_front());
                mon_act = 1'b0;
            end else begin
                chk("wr_done_idle", 128'(dc_wr_done), 128'(1'b0));
            end
        end
    end

    function automatic txn_t mk_rd(input bit dc);
        txn_t t;
        t.wr   = 1'b0;
        t.dc   = dc;
        t.addr = dc ? dc_rd_addr : ic_rd_addr;
        t.len  = (dc ? dc_rd_cached : ic_rd_cached) ? 8'(LW - 1) : 8'd0;
        t.size = (dc && !dc_rd_cached) ? {1'b0, dc_rd_byte_type} : 3'b010;
        t.strb = 4'h0;
        t.line = '0;
        return t;
    endfunction

    function automatic txn_t mk_wr();
        txn_t t;
        t.wr   = 1'b1;
        t.dc   = 1'b1;
        t.addr = dc_wr_addr;
        t.len  = dc_wr_cached ? 8'(LW - 1) : 8'd0;
        t.size = 3'b010;
        t.strb = dc_wr_cached ? 4'hf : dc_wr_strb;
        t.line = dc_wr_line;
        return t;
    endfunction

    task automatic rand_fields();
        ic_rd_cached    = 1'($urandom_range(0, 1));
        ic_rd_addr      = ic_rd_cached ? ($urandom & 32'hffff_fff0) : ($urandom & 32'hffff_fffc);
        dc_rd_cached    = 1'($urandom_range(0, 1));
        dc_rd_addr      = dc_rd_cached ? ($urandom & 32'hffff_fff0) : $urandom;
        dc_rd_byte_type = 2'($urandom_range(0, 2));
        dc_wr_cached    = 1'($urandom_range(0, 1));
        dc_wr_addr      = dc_wr_cached ? ($urandom & 32'hffff_fff0) : $urandom;
        dc_wr_strb      = 4'($urandom_range(1, 15));
        for (int i = 0; i < LW; i++) dc_wr_line[32*i +: 32] = $urandom;
    endtask

    // mask: [2] dc write, [1] dc read, [0] ic read; all raised together
    task automatic issue(input logic [2:0] mask);
        logic [2:0] pend, g;
        bit         first_dc;
        int         cyc;
        if (mask[2]) exp_q.push_back(mk_wr());
        if (mask[1] && mask[0]) begin
`ifdef MEM_ARB_RR_EN
            first_dc = rr_dc;
`else
            first_dc = 1'b1;
`endif
            exp_q.push_back(mk_rd(first_dc));
            exp_q.push_back(mk_rd(!first_dc));
            rr_dc = first_dc;
        end else if (mask[1]) begin
            exp_q.push_back(mk_rd(1'b1));
            rr_dc = 1'b0;
        end else if (mask[0]) begin
            exp_q.push_back(mk_rd(1'b0));
            rr_dc = 1'b1;
        end
        @(posedge clk);
        #1;
        {dc_wr_req, dc_rd_req, ic_rd_req} = mask;
        pend = mask;
        cyc  = 0;
        while (pend != 3'b000 && cyc < 300) begin
            @(negedge clk);
            #3;
            g = {dc_wr_gnt, dc_rd_gnt, ic_rd_gnt};
            @(posedge clk);
            #1;
            if (g[2]) dc_wr_req = 1'b0;
            if (g[1]) dc_rd_req = 1'b0;
            if (g[0]) ic_rd_req = 1'b0;
            pend &= ~g;
            cyc++;
        end
        if (pend != 3'b000) begin
            n_chk++;
            n_fail++;
            $display("FAIL grant_timeout: pending %b, expected 000", pend);
            {dc_wr_req, dc_rd_req, ic_rd_req} = 3'b000;
        end
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL txn_timeout: %0d outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic reset_outputs(input string name);
        chk(name, 128'({arvalid, awvalid, wvalid, wlast, rready, bready,
                        ic_rd_gnt, dc_rd_gnt, dc_wr_gnt, dc_wr_done,
                        ic_rd_valid, dc_rd_valid, ic_rd_last, dc_rd_last}), 128'(0));
    endtask

    task automatic reset_mid_write();
        int cyc;
        rand_fields();
        dc_wr_cached = 1'b1;
        dc_wr_addr   = 32'h0000_4000;
        exp_q.push_back(mk_wr());
        @(posedge clk);
        #1;
        dc_wr_req = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            #3;
            cyc++;
        end while (!(wvalid && mon_beat >= 1) && cyc < 300);
        dc_wr_req = 1'b0;
        if (cyc >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL reset_setup: no second W beat, expected one");
        end
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        reset_outputs("async_reset_outputs");
        exp_q.delete();
        rr_dc = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        {ic_rd_req, dc_rd_req, dc_wr_req} = '0;
        rand_fields();
        repeat (3) @(negedge clk);
        #3;
        reset_outputs("reset_outputs");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        rand_fields();
        ic_rd_cached = 1'b1;
        ic_rd_addr   = 32'h0000_2000;
        dc_rd_cached = 1'b1;
        dc_rd_addr   = 32'h0000_1000;
        issue(3'b011);
        issue(3'b010);

        rand_fields();
        dc_wr_cached = 1'b0;
        dc_wr_addr   = 32'h1fd0_0003;
        dc_wr_strb   = 4'b1000;
        issue(3'b100);

        rand_fields();
        issue(3'b110);
        rand_fields();
        issue(3'b111);

        for (int i = 0; i < 4; i++) begin
            rand_fields();
            issue(3'b011);
        end

        for (int i = 0; i < 40; i++) begin
            rand_fields();
            issue(3'($urandom_range(1, 7)));
        end

        reset_mid_write();
        rand_fields();
        issue(3'b011);
        rand_fields();
        issue(3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single AXI master port between icache refills, dcache refills/uncached loads and dcache writebacks/uncached stores. Sits between the cache controllers behind Memory1/Fetch and the SoC AXI interconnect. Accepts one transaction at a time, drives the AR/R or AW/W/B sequence for it, and returns data beats to the owning requester. Only one outstanding transaction exists.

## Interface
- LINE_WORDS, 4, words per cache line (burst length for cached accesses)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ic_rd_req  in  1  icache read request; held until ic_rd_gnt
- ic_rd_addr  in  32  icache read address (line-aligned when cached)
- ic_rd_cached  in  1  1: LINE_WORDS burst, 0: single beat
- ic_rd_gnt  out  1  1-cycle pulse: request accepted, fields latched
- ic_rd_valid / ic_rd_last  out  1/1  data beat valid / final beat
- dc_rd_req, dc_rd_addr, dc_rd_cached, dc_rd_gnt, dc_rd_valid, dc_rd_last: same as icache set, for dcache
- dc_rd_byte_type  in  2  BYTE/HALF_WORD/WORD, used for arsize when uncached
- rd_data  out  32  shared read data for both read requesters
- dc_wr_req  in  1  dcache write request; held until dc_wr_gnt
- dc_wr_addr  in  32  write address
- dc_wr_cached  in  1  1: full-line writeback, 0: single beat
- dc_wr_line  in  32*LINE_WORDS  line data, latched at grant
- dc_wr_strb  in  4  byte strobes for uncached beat (cached: 4'hf)
- dc_wr_gnt / dc_wr_done  out  1/1  accept pulse / B-response pulse
- AXI AR: araddr 32, arlen 8, arsize 3, arburst 2 (INCR), arid 4, arvalid out, arready in
- AXI R: rdata 32, rlast 1, rvalid in, rready out
- AXI AW: awaddr, awlen, awsize, awburst, awid, awvalid out, awready in
- AXI W: wdata 32, wstrb 4, wlast 1, wvalid out, wready in
- AXI B: bvalid in, bready out

## Operation
- FSM: IDLE, AR, R, AW, W, B.
- IDLE: pick one pending request; fixed priority dc_wr > dc_rd > ic_rd (writeback of victim precedes its refill). Winner gets gnt pulse this cycle; address/size/owner/line/strb latched; next state AR (reads) or AW (write). No request: stay IDLE.
- AR: arvalid=1, arlen = cached ? LINE_WORDS-1 : 0, arsize = cached ? 3'b010 : byte_type, arid = 0 icache / 1 dcache; on arready -> R.
- R: rready=1; each rvalid raises owner's *_rd_valid combinationally with rd_data=rdata; *_rd_last=rlast; on rvalid&rlast -> IDLE.
- AW: awvalid=1, awlen as arlen, awid=1; on awready -> W. Beat counter cleared.
- W: wvalid=1, wdata = latched line word[cnt], wstrb = cached ? 4'hf : latched strb, wlast = (cnt==awlen); on wready cnt++; on wready&wlast -> B.
- B: bready=1; on bvalid pulse dc_wr_done, -> IDLE.
- rresp/bresp ignored. AR and AW never overlap; no pipeline flush aborts a bus transaction.

## Timing
- Reset: state IDLE, all valid/ready/gnt/done/rd_valid/last outputs 0, counters 0, RR pointer = icache.
- Grant in cycle t (IDLE) -> arvalid/awvalid asserted at t+1. Back-to-back transactions: IDLE always occupies one cycle between them.
- rd_valid latency 0 from rvalid; dc_wr_done latency 0 from bvalid.
- AXI valids stay high, payload stable, until ready.
- Request arriving in the same cycle as the previous transaction's final handshake waits for the next IDLE cycle.
- Async reset mid-transaction: immediate IDLE, transaction abandoned; requesters reset together.

## Configuration
- MEM_ARB_RR_EN: defined -> dc_rd and ic_rd arbitrate round-robin (pointer flips to loser after each read grant), dc_wr still highest. Undefined -> fixed dc_rd > ic_rd.

## Structure
- Shared package: arb_state_t enum, arb_owner_t (ICACHE/DCACHE), AXI ID constants, LINE_WORDS default, burst/size constants.
- One sub-module: mem_arb_wbuf (latched line plus beat counter producing wdata/wlast).

## Test plan
- Simultaneous ic_rd_req and dc_rd_req, cached, fixed priority -> dc_rd_gnt first, arid=1 arlen=3; ic granted after rlast.
- Cached dcache refill at 0x1000, rvalid beats with gaps -> 4 dc_rd_valid pulses, dc_rd_last only on 4th, ic_rd_valid never high.
- Uncached store 0x1fd0_0003, strb 4'b1000 -> awlen=0, one beat wstrb=4'b1000 wlast=1, dc_wr_done on bvalid.
- dc_wr_req + dc_rd_req same cycle -> write completes (B) before arvalid asserted.
- MEM_ARB_RR_EN, both read requesters continuously requesting -> grants alternate dc, ic, dc, ic.
- rst_n low during W beat 2 -> all AXI valids 0 immediately, state IDLE, next request granted normally.
